keccak_state_axis_tx: RTL and testbench
=======================================

// Module: keccak_state_axis_tx
// PURPOSE
//  Squeeze-side serializer: captures a full 1600-bit Keccak state (5x5x64 lanes) and streams the first LEN words out as AXI4-Stream beats of DATA_WIDTH bits.
//  Reverse of the input path, where AXI-Stream words are absorbed into the state. Sits between the permutation core and the output AXI-Stream link.
// PARAMETERS
//  DATA_WIDTH  16  TDATA width in bits; must divide 64 (8/16/32/64)
//  ID_WIDTH    2   TID width
//  USER_WIDTH  4   TUSER width
//  LEN_W       7   width of word-count input; must hold 1600/DATA_WIDTH
// PORTS
//  ACLK      in   1                   clock, all logic on rising edge
//  ARESETn   in   1                   asynchronous active-low reset
//  S_in      in   [4:0][4:0][63:0]    Keccak state, S_in[x][y] = lane (x,y)
//  load      in   1                   request: capture S_in/len/id/user
//  len       in   LEN_W               number of output words to send
//  id        in   ID_WIDTH            TID value for this message
//  user      in   USER_WIDTH          TUSER value for this message
//  busy      out  1                   transfer in progress; load ignored
//  done      out  1                   one-cycle pulse after final beat accepted
//  TREADY    in   1                   downstream ready
//  TVALID    out  1                   beat valid
//  TDATA     out  DATA_WIDTH          beat payload
//  TLAST     out  1                   final beat of message
//  TKEEP     out  DATA_WIDTH/8        byte keep
//  TSTRB     out  DATA_WIDTH/8        byte strobe
//  TID       out  ID_WIDTH            stream ID
//  TDEST     out  1                   destination, tied 0
//  TUSER     out  USER_WIDTH          sideband
// BEHAVIOUR
//  Reset (async, ARESETn=0): state IDLE; busy=0, done=0, TVALID=0, TLAST=0; TDATA/TID/TUSER=0; TKEEP=TSTRB=0; count=0, shift reg cleared.
//   Reset mid-transfer aborts immediately; no TLAST is emitted.
//  Word order: lane index i = x + 5*y. The flat vector F[64*i +: 64] = S_in[x][y].
//   Word k = F[DATA_WIDTH*k +: DATA_WIDTH], so each lane goes out LSB-first.
//  FSM IDLE -> SEND -> IDLE:
//   IDLE: load=1 with len!=0 captures F into a 1600-bit shift reg. It also captures Lc=min(len, 1600/DATA_WIDTH), id and user.
//    count<=0 and busy<=1, then go to SEND.
//    load with len==0 is ignored: no capture, no done.
//   SEND: TVALID=1, TDATA=shreg[DATA_WIDTH-1:0], TKEEP=TSTRB=all ones, TID/TUSER=captured values, TLAST=(count==Lc-1).
//    On TVALID&&TREADY: shreg>>=DATA_WIDTH and count++.
//    If the accepted beat had TLAST=1: next cycle TVALID=0, busy=0, done=1 for one cycle, go to IDLE.
//  Latency: load accepted at edge N -> first TVALID=1 in cycle N+1. One beat per cycle when TREADY is held at 1.
//  AXI rules: once TVALID=1, TVALID/TDATA/TLAST/TID/TUSER stay stable until the handshake. TVALID never depends on TREADY.
//  load while busy=1 is ignored, including in the cycle of the last handshake. S_in changing after capture has no effect.
//  Earliest re-load is in the done cycle, since busy=0 there.
//  All outputs are registered.
// STRUCTURE
//  Shared package sha3_axis_pkg holds:
//   - typedef logic [4:0][4:0][63:0] keccak_state_t
//   - localparam STATE_W=1600 and LANE_W=64
//   - function flatten_state(keccak_state_t) -> logic [1599:0], shared with the absorb-side register
//   - enum tx_state_t {IDLE, SEND}
//  No sub-module: a single FSM plus shift register and counter.
// TESTING
//  1) Lane(x,y)=64'h(y)(x)..., load len=16, TREADY=1 -> 16 consecutive beats, word0=lane(0,0)[15:0] ... word15=lane(3,0)[63:48]. TLAST on beat 15 only, done 1 cycle later.
//  2) Same stimulus, TREADY toggling 1,0,0,1,... -> TDATA/TLAST held stable while stalled; same 16-word sequence; no beat lost or duplicated.
//  3) len=1 -> single beat with TLAST=1 and TDATA=lane(0,0)[15:0]. len=0 -> no TVALID and no done. len=127 -> clamped to 100 beats, last beat=lane(4,4)[63:48].
//  4) Second load with different S_in/id while busy -> ignored: output still matches the first capture, TID stays at the first id.
//  5) ARESETn=0 at beat 5 of 16 -> same cycle TVALID=0 and busy=0. After release, a new load streams from word0 with count restarted.
//  6) Back-to-back: load asserted in the done cycle with id=2'b10 -> first beat of the new message in the next cycle with TID=2'b10.

Source files
------------

// File: rtl/sha3_axis_pkg.sv
// Types and helpers shared by the SHA-3 AXI-Stream absorb and squeeze paths.
// Lane (x,y) sits at flat lane index x + 5*y, LSB-first.
package sha3_axis_pkg;

   localparam int STATE_W = 1600;
   localparam int LANE_W  = 64;

   typedef logic [4:0][4:0][63:0] keccak_state_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_t;

   function automatic logic [STATE_W-1:0] flatten_state(input keccak_state_t s);
      logic [STATE_W-1:0] f;
      f = '0;
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 5; x++) begin
            f[LANE_W*(x + 5*y) +: LANE_W] = s[x][y];
         end
      end
      return f;
   endfunction

endpackage

// File: rtl/keccak_state_axis_tx.sv
// Squeeze-side serializer: captures a Keccak state and streams the first len
// words onto AXI4-Stream, lane 0 first, each lane LSB-first.
module keccak_state_axis_tx
   import sha3_axis_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ID_WIDTH   = 2,
   parameter int USER_WIDTH = 4,
   parameter int LEN_W      = 7
) (
   input  logic                        ACLK,
   input  logic                        ARESETn,
   input  logic [4:0][4:0][63:0]       S_in,
   input  logic                        load,
   input  logic [LEN_W-1:0]            len,
   input  logic [ID_WIDTH-1:0]         id,
   input  logic [USER_WIDTH-1:0]       user,
   output logic                        busy,
   output logic                        done,
   input  logic                        TREADY,
   output logic                        TVALID,
   output logic [DATA_WIDTH-1:0]       TDATA,
   output logic                        TLAST,
   output logic [DATA_WIDTH/8-1:0]     TKEEP,
   output logic [DATA_WIDTH/8-1:0]     TSTRB,
   output logic [ID_WIDTH-1:0]         TID,
   output logic                        TDEST,
   output logic [USER_WIDTH-1:0]       TUSER
);

   localparam int KEEP_W = DATA_WIDTH / 8;
   localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(STATE_W / DATA_WIDTH);
   localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

   tx_state_t              state_q, state_d;
   logic [STATE_W-1:0]     shreg_q;
   logic [LEN_W-1:0]       count_q;
   logic [LEN_W-1:0]       lc_q;
   logic [LEN_W-1:0]       len_clamped;
   logic [LEN_W-1:0]       count_next;
   logic                   tvalid_q;
   logic                   tlast_q;
   logic                   busy_q;
   logic                   done_q;
   logic [ID_WIDTH-1:0]    id_q;
   logic [USER_WIDTH-1:0]  user_q;
   logic                   accept;
   logic                   beat;

   assign len_clamped = (len > MAX_WORDS) ? MAX_WORDS : len;
   assign accept      = (state_q == IDLE) && load && (len != '0);
   assign beat        = tvalid_q && TREADY;
   assign count_next  = count_q + ONE;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept)          state_d = SEND;
         SEND: if (beat && tlast_q) state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture on accept, shift one word out per handshake.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         shreg_q  <= '0;
         count_q  <= '0;
         lc_q     <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         id_q     <= '0;
         user_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            shreg_q  <= flatten_state(S_in);
            lc_q     <= len_clamped;
            count_q  <= '0;
            tlast_q  <= (len_clamped == ONE);
            tvalid_q <= 1'b1;
            busy_q   <= 1'b1;
            id_q     <= id;
            user_q   <= user;
         end else if (beat) begin
            shreg_q <= shreg_q >> DATA_WIDTH;
            count_q <= count_next;
            if (tlast_q) begin
               tvalid_q <= 1'b0;
               tlast_q  <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
            end else begin
               tlast_q <= (count_next == (lc_q - ONE));
            end
         end
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign TVALID = tvalid_q;
   assign TDATA  = shreg_q[DATA_WIDTH-1:0];
   assign TLAST  = tlast_q;
   assign TKEEP  = {KEEP_W{tvalid_q}};
   assign TSTRB  = {KEEP_W{tvalid_q}};
   assign TID    = id_q;
   assign TDEST  = 1'b0;
   assign TUSER  = user_q;

endmodule

// File: tb/tb_keccak_state_axis_tx.sv
// Directed bench for keccak_state_axis_tx: word order, stalls, clamping,
// busy-time load rejection, async abort and back-to-back messages.
module tb_keccak_state_axis_tx;

   logic                   clk;
   logic                   rst_n;
   logic [4:0][4:0][63:0]  s_in;
   logic                   load;
   logic [6:0]             len;
   logic [1:0]             id;
   logic [3:0]             user;
   logic                   busy, done;
   logic                   tready, tvalid, tlast, tdest;
   logic [15:0]            tdata;
   logic [1:0]             tkeep, tstrb, tid;
   logic [3:0]             tuser;

   int n_asserts = 0;
   int n_fail    = 0;

   keccak_state_axis_tx #(
      .DATA_WIDTH(16), .ID_WIDTH(2), .USER_WIDTH(4), .LEN_W(7)
   ) dut (
      .ACLK(clk), .ARESETn(rst_n), .S_in(s_in), .load(load), .len(len),
      .id(id), .user(user), .busy(busy), .done(done), .TREADY(tready),
      .TVALID(tvalid), .TDATA(tdata), .TLAST(tlast), .TKEEP(tkeep),
      .TSTRB(tstrb), .TID(tid), .TDEST(tdest), .TUSER(tuser)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Lane (x,y) 16-bit chunk j holds {y, x, j, tag}.
   function automatic logic [4:0][4:0][63:0] build(input logic [3:0] tg);
      logic [4:0][4:0][63:0] s;
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            for (int j = 0; j < 4; j++)
               s[x][y][16*j +: 16] = {4'(y), 4'(x), 4'(j), tg};
      return s;
   endfunction

   function automatic logic [15:0] exp_word(input int k, input logic [3:0] tg);
      int i;
      i = k / 4;
      return {4'(i / 5), 4'(i % 5), 4'(k % 4), tg};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Called at a negedge; leaves the bench at the negedge after the accept edge.
   task automatic do_load(input logic [6:0] l, input logic [3:0] tg,
                          input logic [1:0] i_id, input logic [3:0] i_user);
      s_in = build(tg);
      len  = l;
      id   = i_id;
      user = i_user;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      s_in = build(4'hF);
   endtask

   // Check beats first..stop-1 of an n-word message; mode 1 stalls 2 of 3 cycles.
   task automatic collect(input int n, input int first, input int stop, input int mode,
                          input logic [3:0] tg, input logic [1:0] id_exp,
                          input logic [3:0] user_exp);
      int idx = first;
      int cyc = 0;
      while (idx < stop && cyc < 2000) begin
         tready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         chk("tvalid", 32'(tvalid), 32'd1);
         chk($sformatf("tdata[%0d]", idx), 32'(tdata), 32'(exp_word(idx, tg)));
         chk($sformatf("tlast[%0d]", idx), 32'(tlast), 32'(idx == n - 1));
         if (tready) begin
            chk("tid", 32'(tid), 32'(id_exp));
            chk("tuser", 32'(tuser), 32'(user_exp));
            chk("tkeep", 32'({tkeep, tstrb}), 32'hF);
            idx++;
         end
         @(negedge clk);
         load = 1'b0;
         cyc++;
      end
      if (cyc >= 2000) begin
         n_asserts++;
         n_fail++;
         $error("FAIL collect_timeout observed=%0d expected=%0d", idx, stop);
      end
      if (stop == n) begin
         chk("done_pulse", 32'(done), 32'd1);
         chk("tvalid_end", 32'(tvalid), 32'd0);
         chk("busy_end", 32'(busy), 32'd0);
      end
   endtask

   task automatic done_clears();
      @(negedge clk);
      chk("done_clear", 32'(done), 32'd0);
   endtask

   initial begin
      rst_n  = 1'b0;
      load   = 1'b0;
      len    = '0;
      id     = '0;
      user   = '0;
      tready = 1'b0;
      s_in   = build(4'hF);
      @(negedge clk);
      chk("rst_tvalid", 32'(tvalid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_tlast", 32'(tlast), 32'd0);
      chk("rst_tdata", 32'(tdata), 32'd0);
      chk("rst_keep", 32'({tkeep, tstrb}), 32'd0);
      chk("rst_tid_user", 32'({tid, tuser, tdest}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1) 16 beats at full rate
      do_load(7'd16, 4'hA, 2'b01, 4'h5);
      chk("t1_busy", 32'(busy), 32'd1);
      collect(16, 0, 16, 0, 4'hA, 2'b01, 4'h5);
      done_clears();

      // 2) same with stalls
      do_load(7'd16, 4'hA, 2'b11, 4'h9);
      collect(16, 0, 16, 1, 4'hA, 2'b11, 4'h9);
      done_clears();

      // 3) len=1, len=0, len=127 clamped to 100
      do_load(7'd1, 4'hC, 2'b00, 4'h1);
      collect(1, 0, 1, 0, 4'hC, 2'b00, 4'h1);
      done_clears();
      do_load(7'd0, 4'hC, 2'b00, 4'h1);
      for (int c = 0; c < 3; c++) begin
         chk("len0_tvalid", 32'(tvalid), 32'd0);
         chk("len0_done_busy", 32'({done, busy}), 32'd0);
         @(negedge clk);
      end
      do_load(7'd127, 4'hA, 2'b10, 4'h3);
      collect(100, 0, 100, 0, 4'hA, 2'b10, 4'h3);
      done_clears();

      // 4) load while busy is ignored
      do_load(7'd16, 4'hA, 2'b01, 4'h2);
      collect(16, 0, 3, 0, 4'hA, 2'b01, 4'h2);
      s_in = build(4'hB);
      len  = 7'd5;
      id   = 2'b10;
      user = 4'h7;
      load = 1'b1;
      collect(16, 3, 16, 0, 4'hA, 2'b01, 4'h2);
      done_clears();

      // 5) async reset mid-message, then restart from word 0
      do_load(7'd16, 4'hA, 2'b01, 4'h4);
      collect(16, 0, 5, 0, 4'hA, 2'b01, 4'h4);
      rst_n = 1'b0;
      #1;
      chk("abort_tvalid", 32'(tvalid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_tlast", 32'(tlast), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_load(7'd16, 4'hD, 2'b11, 4'h6);
      collect(16, 0, 16, 0, 4'hD, 2'b11, 4'h6);

      // 6) reload in the done cycle
      do_load(7'd4, 4'hE, 2'b10, 4'h8);
      chk("b2b_tid", 32'(tid), 32'(2'b10));
      chk("b2b_done_clear", 32'(done), 32'd0);
      collect(4, 0, 4, 0, 4'hE, 2'b10, 4'h8);
      done_clears();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
